kfmmc_spi_xfer: RTL and testbench

Parametrised SPI master transfer engine for the KFMMC card path. It is the successor of the fixed 8-bit, mode-0 byte shifter. Each transfer moves one word of configurable width in any SPI mode (CPOL/CPHA), with a programmable clock divider. It drives per-device chip selects, with optional CS hold across words for multi-word commands, and signals completion with a one-cycle done pulse. It sits between the KFMMC command/data sequencer and the card pins.

---
 rtl/kfmmc_spi_pkg.sv | 31 +++
 rtl/kfmmc_spi_clkgen.sv | 32 +++
 rtl/kfmmc_spi_xfer.sv | 142 ++++++++++++++
 tb/tb_kfmmc_spi_xfer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kfmmc_spi_pkg.sv
// kfmmc_spi_pkg: shared types and helpers for the KFMMC SPI transfer engine.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

package kfmmc_spi_pkg;

  localparam int HALF_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_END   = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Half SCK period in system clocks; periods of 0 and 1 both collapse to 1.
  function automatic logic [HALF_W-1:0] calc_half(input logic [HALF_W-1:0] cycle);
    logic [HALF_W-1:0] h;
    h = cycle >> 1;
    return (h == '0) ? HALF_W'(1) : h;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kfmmc_spi_clkgen.sv
// kfmmc_spi_clkgen: half-period counter producing one edge strobe every i_half cycles.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module kfmmc_spi_clkgen
  import kfmmc_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [HALF_W-1:0] i_half,
  output logic              o_edge
);

  logic [HALF_W-1:0] r_cnt;

  assign o_edge = i_en && (r_cnt >= i_half);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= HALF_W'(1);
    end else if (!i_en || o_edge) begin
      r_cnt <= HALF_W'(1);
    end else begin
      r_cnt <= r_cnt + HALF_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/kfmmc_spi_xfer.sv
// kfmmc_spi_xfer: SPI master moving one DATA_WIDTH word per start in any CPOL/CPHA mode.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module kfmmc_spi_xfer
  import kfmmc_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CS_COUNT   = 1
) (
  input  logic                                              clock,
  input  logic                                              reset_n,
  input  logic [DATA_WIDTH-1:0]                             send_data,
  output logic [DATA_WIDTH-1:0]                             recv_data,
  input  logic                                              start_communication,
  input  logic [((CS_COUNT > 1) ? $clog2(CS_COUNT) : 1)-1:0] cs_select,
  input  logic                                              cs_hold,
  input  logic                                              cs_release,
  input  logic                                              cpol,
  input  logic                                              cpha,
  input  logic [7:0]                                        spi_clock_cycle,
  output logic                                              busy_flag,
  output logic                                              done,
  output logic                                              spi_clk,
  output logic                                              spi_mosi,
  output logic [CS_COUNT-1:0]                               spi_cs_n,
  input  logic                                              spi_miso
);

  localparam int EC_W = $clog2(2 * DATA_WIDTH + 1);

  spi_state_t            r_state, w_next;
  spi_mode_t             r_mode;
  logic                  r_hold;
  logic [HALF_W-1:0]     r_half;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_recv;
  logic [EC_W-1:0]       r_edge_cnt;
  logic [CS_COUNT-1:0]   r_cs_n, w_cs_dec;
  logic                  r_sck, r_mosi, r_done;
  logic                  w_edge, w_accept, w_xfer_edge, w_end_edge;
  logic                  w_last_edge, w_leading, w_sample, w_shift;

  kfmmc_spi_clkgen u_clkgen (
    .clk    (clock),
    .rst_n  (reset_n),
    .i_en   (r_state != ST_IDLE),
    .i_half (r_half),
    .o_edge (w_edge)
  );

  // Edge numbers are 1-based: odd edges (even count before the edge) are leading.
  assign w_accept    = (r_state == ST_IDLE) && start_communication;
  assign w_xfer_edge = (r_state == ST_XFER) && w_edge;
  assign w_end_edge  = (r_state == ST_END) && w_edge;
  assign w_last_edge = (r_edge_cnt == EC_W'(2 * DATA_WIDTH - 1));
  assign w_leading   = ~r_edge_cnt[0];
  assign w_sample    = w_xfer_edge && (w_leading != r_mode.cpha);
  assign w_shift     = w_xfer_edge && (w_leading == r_mode.cpha) && !w_last_edge;

  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < CS_COUNT; i++) begin
      if (int'(cs_select) == i) w_cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_communication)  w_next = ST_SETUP;
      ST_SETUP: if (w_edge)               w_next = ST_XFER;
      ST_XFER:  if (w_edge && w_last_edge) w_next = ST_END;
      ST_END:   if (w_edge)               w_next = ST_IDLE;
      default:                            w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= '0;
      r_hold     <= 1'b0;
      r_half     <= HALF_W'(1);
      r_tx       <= '0;
      r_rx       <= '0;
      r_recv     <= '0;
      r_edge_cnt <= '0;
      r_cs_n     <= '1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_mode     <= '{cpol: cpol, cpha: cpha};
        r_hold     <= cs_hold;
        r_half     <= calc_half(spi_clock_cycle);
        r_edge_cnt <= '0;
        r_cs_n     <= w_cs_dec;
        r_sck      <= cpol;
        // cpha=0 presents the MSB during SETUP; cpha=1 shifts it out on the first edge.
        r_tx       <= cpha ? send_data : {send_data[DATA_WIDTH-2:0], 1'b0};
        r_mosi     <= cpha ? 1'b1 : send_data[DATA_WIDTH-1];
      end else if ((r_state == ST_IDLE) && cs_release) begin
        r_cs_n <= '1;
      end

      if (w_xfer_edge) begin
        r_edge_cnt <= r_edge_cnt + EC_W'(1);
        r_sck      <= w_last_edge ? r_mode.cpol : ~r_sck;
        if (w_sample) r_rx <= {r_rx[DATA_WIDTH-2:0], spi_miso};
        if (w_shift) begin
          r_mosi <= r_tx[DATA_WIDTH-1];
          r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
        end
        if (w_last_edge) r_mosi <= 1'b1;
      end

      if (w_end_edge) begin
        r_recv <= r_rx;
        r_done <= 1'b1;
        if (!r_hold) r_cs_n <= '1;
      end
    end
  end

  assign busy_flag = !reset_n || (r_state != ST_IDLE);
  assign done      = r_done;
  assign recv_data = r_recv;
  assign spi_clk   = r_sck;
  assign spi_mosi  = r_mosi;
  assign spi_cs_n  = r_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_kfmmc_spi_xfer.sv
// tb_kfmmc_spi_xfer: directed checks of kfmmc_spi_xfer with an SPI slave model and a loopback instance.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_kfmmc_spi_xfer;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Instance A: 8-bit words, four chip selects, driven by the slave model below.
  logic [7:0] a_send, a_recv;
  logic       a_start, a_hold, a_rel, a_cpol, a_cpha, a_busy, a_done, a_sck, a_mosi, a_miso;
  logic [1:0] a_sel;
  logic [7:0] a_cyc;
  logic [3:0] a_cs;

  // Instance B: 16-bit words, five chip selects so an unused select code (5) exists, MISO looped to MOSI.
  logic [15:0] b_send, b_recv;
  logic        b_start, b_hold, b_rel, b_cpol, b_cpha, b_busy, b_done, b_sck, b_mosi, b_miso;
  logic [2:0]  b_sel;
  logic [7:0]  b_cyc;
  logic [4:0]  b_cs;

  kfmmc_spi_xfer #(.DATA_WIDTH(8), .CS_COUNT(4)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .send_data(a_send), .recv_data(a_recv),
    .start_communication(a_start), .cs_select(a_sel), .cs_hold(a_hold), .cs_release(a_rel),
    .cpol(a_cpol), .cpha(a_cpha), .spi_clock_cycle(a_cyc), .busy_flag(a_busy), .done(a_done),
    .spi_clk(a_sck), .spi_mosi(a_mosi), .spi_cs_n(a_cs), .spi_miso(a_miso)
  );

  kfmmc_spi_xfer #(.DATA_WIDTH(16), .CS_COUNT(5)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .send_data(b_send), .recv_data(b_recv),
    .start_communication(b_start), .cs_select(b_sel), .cs_hold(b_hold), .cs_release(b_rel),
    .cpol(b_cpol), .cpha(b_cpha), .spi_clock_cycle(b_cyc), .busy_flag(b_busy), .done(b_done),
    .spi_clk(b_sck), .spi_mosi(b_mosi), .spi_cs_n(b_cs), .spi_miso(b_miso)
  );

  assign b_miso = b_mosi;

  // Slave model: edges detected at negedge against the previous negedge's SCK level.
  logic       m_cpol = 1'b0, m_cpha = 1'b0;
  logic [7:0] slv_word = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  logic       sck_prev = 1'b0, mosi_prev = 1'b1;
  int         s_lead = 0, s_trail = 0, s_idx;

  always @(negedge clock) begin
    if (!a_busy) begin
      s_lead  <= 0;
      s_trail <= 0;
    end else if (a_sck != sck_prev) begin
      if (a_sck != m_cpol) begin
        s_lead <= s_lead + 1;
        if (!m_cpha) mosi_cap <= {mosi_cap[6:0], mosi_prev};
      end else if (s_lead > s_trail) begin
        s_trail <= s_trail + 1;
        if (m_cpha) mosi_cap <= {mosi_cap[6:0], mosi_prev};
      end
    end
    sck_prev  <= a_sck;
    mosi_prev <= a_mosi;
  end

  always_comb begin
    s_idx  = m_cpha ? ((s_lead == 0) ? 0 : s_lead - 1) : s_trail;
    a_miso = (s_idx > 7) ? 1'b1 : slv_word[7 - s_idx];
  end

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input bit inst, input logic [15:0] send, input logic pol, input logic pha,
                        input logic [2:0] sel, input logic hold, input logic [7:0] cyc, input logic rel);
    if (!inst) begin
      a_send = send[7:0]; a_cpol = pol; a_cpha = pha; a_sel = sel[1:0];
      a_hold = hold; a_cyc = cyc; a_rel = rel; a_start = 1'b1;
    end else begin
      b_send = send; b_cpol = pol; b_cpha = pha; b_sel = sel;
      b_hold = hold; b_cyc = cyc; b_rel = rel; b_start = 1'b1;
    end
    @(posedge clock);
    #1;
    a_start = 1'b0; a_rel = 1'b0; b_start = 1'b0; b_rel = 1'b0;
  endtask

  // Counts busy cycles until done; returns at the negedge where done is seen.
  task automatic wait_done(input bit inst, input logic [7:0] exp_cs, output int n, output int bad);
    bit got;
    got = 1'b0; n = 0; bad = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (inst ? b_done : a_done) begin
        got = 1'b1;
        break;
      end
      n++;
      if ((inst ? {3'b000, b_cs} : {4'b0000, a_cs}) !== exp_cs) bad++;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
  endtask

  int n, bad, dcnt;

  initial begin
    reset_n = 1'b0;
    a_send = '0; a_start = 0; a_sel = '0; a_hold = 0; a_rel = 0; a_cpol = 0; a_cpha = 0; a_cyc = '0;
    b_send = '0; b_start = 0; b_sel = '0; b_hold = 0; b_rel = 0; b_cpol = 0; b_cpha = 0; b_cyc = '0;
    #12;
    chk("rst_busy", a_busy, 1);
    chk("rst_sck",  a_sck, 0);
    chk("rst_mosi", a_mosi, 1);
    chk("rst_cs",   a_cs, 4'hF);
    chk("rst_recv", a_recv, 0);
    chk("rst_done", a_done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_busy", a_busy, 0);

    // Mode 0, H = 2
    m_cpol = 0; m_cpha = 0; slv_word = 8'h3C;
    launch(0, 16'h00A5, 0, 0, 3'd0, 0, 8'd4, 0);
    chk("m0_busy", a_busy, 1);
    chk("m0_setup_sck", a_sck, 0);
    chk("m0_setup_mosi", a_mosi, 1);
    chk("m0_cs", a_cs, 4'b1110);
    wait_done(0, 8'b1110, n, bad);
    chk("m0_len", n, 36);
    chk("m0_cs_during", bad, 0);
    chk("m0_recv", a_recv, 8'h3C);
    chk("m0_mosi_bits", mosi_cap, 8'hA5);
    chk("m0_busy_at_done", a_busy, 0);
    chk("m0_cs_after", a_cs, 4'hF);
    @(negedge clock);
    chk("m0_done_pulse", a_done, 0);

    for (int m = 1; m < 4; m++) begin
      m_cpol = m[1]; m_cpha = m[0]; slv_word = 8'h3C;
      launch(0, 16'h00A5, m[1], m[0], 3'd1, 0, 8'd4, 0);
      chk("mode_setup_sck", a_sck, m[1]);
      wait_done(0, 8'b1101, n, bad);
      chk("mode_len", n, 36);
      chk("mode_cs_during", bad, 0);
      chk("mode_recv", a_recv, 8'h3C);
      chk("mode_mosi_bits", mosi_cap, 8'hA5);
      chk("mode_idle_sck", a_sck, m[1]);
      @(negedge clock);
    end

    // Back-to-back words on CS 2 with hold; second start coincides with done and a release request.
    m_cpol = 0; m_cpha = 0; slv_word = 8'h3C;
    launch(0, 16'h00A5, 0, 0, 3'd2, 1, 8'd4, 0);
    wait_done(0, 8'b1011, n, bad);
    chk("b2b1_cs_during", bad, 0);
    chk("b2b1_recv", a_recv, 8'h3C);
    chk("b2b1_cs_done", a_cs, 4'b1011);
    slv_word = 8'hC3;
    launch(0, 16'h005A, 0, 0, 3'd2, 1, 8'd4, 1);
    chk("b2b2_cs_start", a_cs, 4'b1011);
    wait_done(0, 8'b1011, n, bad);
    chk("b2b2_len", n, 36);
    chk("b2b2_cs_during", bad, 0);
    chk("b2b2_recv", a_recv, 8'hC3);
    chk("b2b2_mosi_bits", mosi_cap, 8'h5A);
    chk("b2b2_cs_held", a_cs, 4'b1011);
    @(negedge clock);
    a_rel = 1'b1;
    @(posedge clock);
    #1;
    a_rel = 1'b0;
    chk("release_cs", a_cs, 4'hF);

    // Start pulsed mid-transfer must not disturb the running word.
    slv_word = 8'h3C;
    launch(0, 16'h00A5, 0, 0, 3'd0, 0, 8'd4, 0);
    repeat (10) @(negedge clock);
    a_send = 8'hFF; a_start = 1'b1;
    @(posedge clock);
    #1;
    a_start = 1'b0;
    wait_done(0, 8'b1110, n, bad);
    chk("ign_len", n + 10, 36);
    chk("ign_recv", a_recv, 8'h3C);
    chk("ign_mosi_bits", mosi_cap, 8'hA5);
    @(negedge clock);
    chk("ign_idle", a_busy, 0);

    // Asynchronous reset in the middle of XFER.
    m_cpol = 1; m_cpha = 1;
    launch(0, 16'h00A5, 1, 1, 3'd3, 1, 8'd4, 0);
    repeat (12) @(negedge clock);
    chk("pre_rst_cs", a_cs, 4'b0111);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cs", a_cs, 4'hF);
    chk("mid_rst_mosi", a_mosi, 1);
    chk("mid_rst_sck", a_sck, 0);
    chk("mid_rst_busy", a_busy, 1);
    chk("mid_rst_recv", a_recv, 0);
    @(negedge clock);
    reset_n = 1'b1;
    dcnt = 0;
    repeat (50) begin
      @(negedge clock);
      if (a_done) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);
    chk("mid_rst_idle", a_busy, 0);

    // 16-bit loopback at H = 1.
    launch(1, 16'hBEEF, 0, 0, 3'd0, 0, 8'd0, 0);
    chk("w16_cs", b_cs, 5'b11110);
    wait_done(1, 8'b00011110, n, bad);
    chk("w16_len", n, 34);
    chk("w16_cs_during", bad, 0);
    chk("w16_recv", b_recv, 16'hBEEF);
    @(negedge clock);

    // Select code beyond CS_COUNT: no CS asserted, transfer still completes.
    launch(1, 16'h1234, 0, 1, 3'd5, 0, 8'd1, 0);
    chk("oor_cs", b_cs, 5'h1F);
    wait_done(1, 8'h1F, n, bad);
    chk("oor_len", n, 34);
    chk("oor_cs_during", bad, 0);
    chk("oor_recv", b_recv, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
